// File: rtl/if_fetch_unit.sv
// SimpleRisc instruction-fetch stage: PC register, IMem handshake,
// one-entry skid buffer for Stall and branch squash of in-flight fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] PC_Current,
  output logic [31:0] Instruction,
  output logic        Inst_Valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, SQUASH} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;

  logic        ack;
  logic [31:0] fetch_pc_d;

  // An Ack is only meaningful against an outstanding request.
  assign ack        = IMem_Ack & req_q;
  assign fetch_pc_d = fetch_pc_q + STEP;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
    end else begin
      if (!Stall) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
      if (Branch_Taken) begin
        valid_q    <= 1'b0;
        instr_q    <= NOP_INSTR;
        fetch_pc_q <= Branch_PC;
        // An unanswered request must keep its address until Ack.
        if ((state_q == REQ || state_q == SQUASH) && !ack) begin
          state_q <= SQUASH;
        end else begin
          state_q <= REQ;
          req_q   <= 1'b1;
          addr_q  <= Branch_PC;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
          REQ: begin
            if (ack) begin
              fetch_pc_q <= fetch_pc_d;
              addr_q     <= fetch_pc_d;
              if (!valid_q || !Stall) begin
                pc_q    <= fetch_pc_q;
                instr_q <= IMem_Data;
                valid_q <= 1'b1;
              end else begin
                skid_pc_q    <= fetch_pc_q;
                skid_instr_q <= IMem_Data;
                state_q      <= HOLD;
                req_q        <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!Stall) begin
              pc_q    <= skid_pc_q;
              instr_q <= skid_instr_q;
              valid_q <= 1'b1;
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
          SQUASH: begin
            if (ack) begin
              state_q <= REQ;
              addr_q  <= fetch_pc_q;
            end
          end
        endcase
      end
    end
  end

  assign IMem_Req    = req_q;
  assign IMem_Addr   = addr_q;
  assign PC_Current  = pc_q;
  assign Instruction = instr_q;
  assign Inst_Valid  = valid_q;

endmodule
